pipe_ctrl_track: RTL

- Carries the decoded control word from ID through the EX, MEM and WB pipeline registers of the 5-stage MIPS pipeline.
- Detects load-use hazards and generates the stall.
- Generates the IF/ID flush for jumps and taken branches.
- Drives the EX-stage operand forwarding selects.
- Keeps saturating stall and flush event counters for debug.
- Sits between the instruction decoder (consumer of its ID outputs) and the datapath stage registers.

---
 rtl/pipe_ctrl_track_if.sv | 85 ++++++++
 rtl/pipe_ctrl_track.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_track_if.sv
// Bus between the ID-stage decoder, the datapath stage registers and pipe_ctrl_track.
// Carries the decoded ID controls in, and the per-stage controls, hazard and forwarding selects out.
interface pipe_ctrl_track_if #(
  parameter int CNT_W = 16
);

  // ID side
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             id_RegWrite;
  logic             id_MemToReg;
  logic             id_MemWrite;
  logic             id_BranchEq;
  logic             id_Jump;
  logic             id_ALUSrc;
  logic             id_RegDst;
  logic             id_LoadCtrl;
  logic [2:0]       id_ALUc;
  logic             ex_branch_taken;

  // Hazard control
  logic             stall;
  logic             flush_id;

  // EX stage
  logic [2:0]       ex_ALUc;
  logic             ex_ALUSrc;
  logic             ex_BranchEq;
  logic             ex_MemWrite;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_wreg;

  // MEM stage
  logic             mem_RegWrite;
  logic             mem_MemToReg;
  logic             mem_MemWrite;
  logic             mem_LoadCtrl;
  logic [4:0]       mem_wreg;

  // WB stage
  logic             wb_RegWrite;
  logic             wb_MemToReg;
  logic             wb_LoadCtrl;
  logic [4:0]       wb_wreg;

  // Forwarding selects and debug counters
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Handshake: id_valid marks ID as holding a real instruction. stall is the
  // backpressure: while it is high the producer keeps PC and IF/ID unchanged
  // and the same instruction is re-presented next cycle. No ID instruction is
  // accepted into EX in a cycle with stall=1, ex_branch_taken=1 or id_valid=0.
  modport slave (
    input  id_valid, id_rs, id_rt, id_rd,
    input  id_RegWrite, id_MemToReg, id_MemWrite, id_BranchEq,
    input  id_Jump, id_ALUSrc, id_RegDst, id_LoadCtrl, id_ALUc,
    input  ex_branch_taken,
    output stall, flush_id,
    output ex_ALUc, ex_ALUSrc, ex_BranchEq, ex_MemWrite,
    output ex_rs, ex_rt, ex_wreg,
    output mem_RegWrite, mem_MemToReg, mem_MemWrite, mem_LoadCtrl, mem_wreg,
    output wb_RegWrite, wb_MemToReg, wb_LoadCtrl, wb_wreg,
    output fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport master (
    output id_valid, id_rs, id_rt, id_rd,
    output id_RegWrite, id_MemToReg, id_MemWrite, id_BranchEq,
    output id_Jump, id_ALUSrc, id_RegDst, id_LoadCtrl, id_ALUc,
    output ex_branch_taken,
    input  stall, flush_id,
    input  ex_ALUc, ex_ALUSrc, ex_BranchEq, ex_MemWrite,
    input  ex_rs, ex_rt, ex_wreg,
    input  mem_RegWrite, mem_MemToReg, mem_MemWrite, mem_LoadCtrl, mem_wreg,
    input  wb_RegWrite, wb_MemToReg, wb_LoadCtrl, wb_wreg,
    input  fwd_a, fwd_b, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_track.sv
// Control-word pipeline for a 5-stage MIPS core: ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, IF/ID flush, EX operand forwarding selects and saturating debug counters.
module pipe_ctrl_track #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_ctrl_track_if.slave      bus
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch_eq;
    logic       alu_src;
    logic       load_ctrl;
    logic [2:0] alu_c;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
  } idex_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       load_ctrl;
    logic [4:0] wreg;
  } exmem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       load_ctrl;
    logic [4:0] wreg;
  } memwb_t;

  idex_t            idex_q,      idex_d;
  exmem_t           exmem_q,     exmem_d;
  memwb_t           memwb_q,     memwb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [4:0] id_wreg;
  logic       id_uses_rt;
  logic       load_use;
  logic       stall;
  logic       flush_id;
  logic       bubble;

  // EX/MEM beats MEM/WB because it holds the younger write to the same register.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input exmem_t    m,
                                         input memwb_t    w);
    logic [1:0] sel;
    sel = 2'b00;
    if (m.reg_write && (m.wreg != 5'd0) && (m.wreg == src)) begin
      sel = 2'b10;
    end else if (w.reg_write && (w.wreg != 5'd0) && (w.wreg == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Hazard detection
  always_comb begin
    id_wreg    = bus.id_RegDst ? bus.id_rt : bus.id_rd;
    id_uses_rt = !bus.id_ALUSrc || bus.id_MemWrite || bus.id_BranchEq;
    load_use   = idex_q.mem_to_reg && (idex_q.wreg != 5'd0) &&
                 ((idex_q.wreg == bus.id_rs) ||
                  (id_uses_rt && (idex_q.wreg == bus.id_rt)));
    // A taken branch squashes the ID instruction anyway, so it never needs to wait.
    stall      = bus.id_valid && load_use && !bus.ex_branch_taken;
    flush_id   = bus.ex_branch_taken || (bus.id_valid && bus.id_Jump && !stall);
    bubble     = stall || bus.ex_branch_taken || !bus.id_valid;
  end

  // ID/EX next value
  always_comb begin
    idex_d = '0;
    if (!bubble) begin
      idex_d.reg_write  = bus.id_RegWrite && (id_wreg != 5'd0);
      idex_d.mem_to_reg = bus.id_MemToReg;
      idex_d.mem_write  = bus.id_MemWrite;
      idex_d.branch_eq  = bus.id_BranchEq;
      idex_d.alu_src    = bus.id_ALUSrc;
      idex_d.load_ctrl  = bus.id_LoadCtrl;
      idex_d.alu_c      = bus.id_ALUc;
      idex_d.rs         = bus.id_rs;
      idex_d.rt         = bus.id_rt;
      idex_d.wreg       = id_wreg;
    end
  end

  // EX/MEM and MEM/WB always advance
  always_comb begin
    exmem_d            = '0;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.load_ctrl  = idex_q.load_ctrl;
    exmem_d.wreg       = idex_q.wreg;

    memwb_d            = '0;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.load_ctrl  = exmem_q.load_ctrl;
    memwb_d.wreg       = exmem_q.wreg;
  end

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_id && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Outputs
  always_comb begin
    bus.stall        = stall;
    bus.flush_id     = flush_id;

    bus.ex_ALUc      = idex_q.alu_c;
    bus.ex_ALUSrc    = idex_q.alu_src;
    bus.ex_BranchEq  = idex_q.branch_eq;
    bus.ex_MemWrite  = idex_q.mem_write;
    bus.ex_rs        = idex_q.rs;
    bus.ex_rt        = idex_q.rt;
    bus.ex_wreg      = idex_q.wreg;

    bus.mem_RegWrite = exmem_q.reg_write;
    bus.mem_MemToReg = exmem_q.mem_to_reg;
    bus.mem_MemWrite = exmem_q.mem_write;
    bus.mem_LoadCtrl = exmem_q.load_ctrl;
    bus.mem_wreg     = exmem_q.wreg;

    bus.wb_RegWrite  = memwb_q.reg_write;
    bus.wb_MemToReg  = memwb_q.mem_to_reg;
    bus.wb_LoadCtrl  = memwb_q.load_ctrl;
    bus.wb_wreg      = memwb_q.wreg;

    bus.fwd_a        = fwd_sel(idex_q.rs, exmem_q, memwb_q);
    bus.fwd_b        = fwd_sel(idex_q.rt, exmem_q, memwb_q);
    bus.stall_cnt    = stall_cnt_q;
    bus.flush_cnt    = flush_cnt_q;
  end

endmodule
